serial_subtractor_8bit: RTL and testbench

- Bit-serial unsigned subtractor for the SAP-1 ALU path. It computes diff = a - b one bit per clock, LSB first, using a single 1-bit full-subtractor cell.
- It complements the combinational 8-bit unsigned adder. It gives the accumulator datapath subtraction with a borrow-out flag and a start/done handshake.
- It sits between the A/B registers and the accumulator write-back mux.

---
 rtl/sap1_pkg.sv | 18 +
 rtl/full_subtractor_1bit.sv | 13 +
 rtl/serial_subtractor_8bit.sv | 93 +++++++++
 tb/tb_serial_subtractor_8bit.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/sap1_pkg.sv
// Shared SAP-1 datapath types and constants.
// The sequencer state encoding and helpers live here so ALU blocks agree on them.
package sap1_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int SAP1_DATA_W = 8;

   // Bit counter width; counts 0..width-1.
   function automatic int cnt_w(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/full_subtractor_1bit.sv
// Single-bit full subtractor: d = x - y - bin, bout set when the bit underflows.
module full_subtractor_1bit (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock through one cell.
// Results are published on the cycle after the last bit, together with a done pulse.
module serial_subtractor_8bit
   import sap1_pkg::*;
#(
   parameter int WIDTH = SAP1_DATA_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             zero,
   output logic             busy,
   output logic             done
);

   localparam int CW = cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic             borrow_int;
   logic [CW-1:0]    cnt;
   logic             d;
   logic             bo;

   full_subtractor_1bit u_fs (
      .x    (a_sh[0]),
      .y    (b_sh[0]),
      .bin  (borrow_int),
      .d    (d),
      .bout (bo)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         a_sh       <= '0;
         b_sh       <= '0;
         res_sh     <= '0;
         borrow_int <= 1'b0;
         cnt        <= '0;
         diff       <= '0;
         borrow     <= 1'b0;
         zero       <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               // Publish in DONE; a start on this same edge still loads cleanly
               // because the outputs read the pre-edge shift state.
               if (state == DONE) begin
                  diff   <= res_sh;
                  borrow <= borrow_int;
                  zero   <= (res_sh == '0);
                  done   <= 1'b1;
               end
               if (start) begin
                  a_sh       <= a;
                  b_sh       <= b;
                  res_sh     <= '0;
                  borrow_int <= 1'b0;
                  cnt        <= '0;
                  busy       <= 1'b1;
                  state      <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               res_sh     <= {d, res_sh[WIDTH-1:1]};
               a_sh       <= a_sh >> 1;
               b_sh       <= b_sh >> 1;
               borrow_int <= bo;
               cnt        <= cnt + 1'b1;
               if (cnt == LAST) begin
                  busy  <= 1'b0;
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Directed checks of the serial subtractor: latency, wrap-around, ignored starts,
// async reset mid-operation and back-to-back operation.
module tb_serial_subtractor_8bit;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic [7:0] diff;
   logic       borrow, zero, busy, done;

   int errors = 0;
   int checks = 0;

   serial_subtractor_8bit #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .diff(diff), .borrow(borrow), .zero(zero), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Issue one op at a negedge; k counts negedges after the start edge (k=0 right after it).
   // An optional spurious start (FF-FF) is driven at k == inj_k.
   task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input int inj_k,
                         output int lat, output int bcnt, output int dcnt);
      @(negedge clk); a = av; b = bv; start = 1'b1;
      @(negedge clk); start = 1'b0; a = 8'h00; b = 8'h00;
      lat = -1; bcnt = 0; dcnt = 0;
      for (int k = 0; k < 14; k++) begin
         if (k > 0) @(negedge clk);
         if (busy) bcnt++;
         if (done) begin dcnt++; if (lat < 0) lat = k; end
         if (k == inj_k) begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
         else if (k == inj_k + 1) begin start = 1'b0; a = 8'h00; b = 8'h00; end
      end
   endtask

   task automatic test_reset;
      #2;
      checks++; if ({diff, borrow, zero, busy, done} !== 12'h000) begin errors++;
         $display("FAIL reset_outputs: got %h expected 000", {diff, borrow, zero, busy, done}); end
      @(negedge clk); @(negedge clk); rst = 1'b0;
      @(negedge clk);
      checks++; if ({busy, done} !== 2'b00) begin errors++;
         $display("FAIL reset_idle: got %b expected 00", {busy, done}); end
   endtask

   task automatic test_basic;
      int lat, bc, dc;
      run_op(8'h03, 8'h01, -1, lat, bc, dc);
      checks++; if (lat !== 9) begin errors++; $display("FAIL basic_latency: got %0d expected 9", lat); end
      checks++; if (bc !== 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 8", bc); end
      checks++; if (dc !== 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", dc); end
      checks++; if (diff !== 8'h02) begin errors++; $display("FAIL basic_diff: got %h expected 02", diff); end
      checks++; if ({borrow, zero} !== 2'b00) begin errors++; $display("FAIL basic_flags: got %b expected 00", {borrow, zero}); end
   endtask

   task automatic test_wrap;
      int lat, bc, dc;
      run_op(8'h01, 8'h02, -1, lat, bc, dc);
      checks++; if (diff !== 8'hFF) begin errors++; $display("FAIL wrap1_diff: got %h expected ff", diff); end
      checks++; if ({borrow, zero} !== 2'b10) begin errors++; $display("FAIL wrap1_flags: got %b expected 10", {borrow, zero}); end
      run_op(8'h00, 8'hFF, -1, lat, bc, dc);
      checks++; if (diff !== 8'h01) begin errors++; $display("FAIL wrap2_diff: got %h expected 01", diff); end
      checks++; if ({borrow, zero} !== 2'b10) begin errors++; $display("FAIL wrap2_flags: got %b expected 10", {borrow, zero}); end
   endtask

   task automatic test_ripple_zero;
      int lat, bc, dc;
      run_op(8'h10, 8'h01, -1, lat, bc, dc);
      checks++; if (diff !== 8'h0F) begin errors++; $display("FAIL ripple_diff: got %h expected 0f", diff); end
      checks++; if ({borrow, zero} !== 2'b00) begin errors++; $display("FAIL ripple_flags: got %b expected 00", {borrow, zero}); end
      run_op(8'h5A, 8'h5A, -1, lat, bc, dc);
      checks++; if (diff !== 8'h00) begin errors++; $display("FAIL equal_diff: got %h expected 00", diff); end
      checks++; if ({borrow, zero} !== 2'b01) begin errors++; $display("FAIL equal_flags: got %b expected 01", {borrow, zero}); end
      checks++; if (dc !== 1) begin errors++; $display("FAIL equal_done_count: got %0d expected 1", dc); end
   endtask

   task automatic test_start_while_busy;
      int lat, bc, dc;
      run_op(8'h80, 8'h01, 3, lat, bc, dc);
      checks++; if (diff !== 8'h7F) begin errors++; $display("FAIL busy_start_diff: got %h expected 7f", diff); end
      checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL busy_start_borrow: got %b expected 0", borrow); end
      checks++; if (dc !== 1) begin errors++; $display("FAIL busy_start_done_count: got %0d expected 1", dc); end
      checks++; if (lat !== 9) begin errors++; $display("FAIL busy_start_latency: got %0d expected 9", lat); end
   endtask

   task automatic test_reset_mid;
      int lat, bc, dc, dseen;
      @(negedge clk); a = 8'h20; b = 8'h05; start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int k = 1; k < 4; k++) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before_rst: got %b expected 1", busy); end
      #2 rst = 1'b1;
      #1;
      checks++; if ({diff, borrow, zero, busy, done} !== 12'h000) begin errors++;
         $display("FAIL mid_rst_async: got %h expected 000", {diff, borrow, zero, busy, done}); end
      dseen = 0;
      @(negedge clk); @(negedge clk); rst = 1'b0;
      for (int k = 0; k < 12; k++) begin @(negedge clk); if (done) dseen++; end
      checks++; if (dseen !== 0) begin errors++; $display("FAIL mid_rst_no_done: got %0d expected 0", dseen); end
      run_op(8'h20, 8'h05, -1, lat, bc, dc);
      checks++; if (diff !== 8'h1B) begin errors++; $display("FAIL after_rst_diff: got %h expected 1b", diff); end
      checks++; if (lat !== 9) begin errors++; $display("FAIL after_rst_latency: got %0d expected 9", lat); end
   endtask

   task automatic test_back_to_back;
      int lat2, holdbad, first_ok;
      lat2 = -1; holdbad = 0; first_ok = 0;
      @(negedge clk); a = 8'h30; b = 8'h10; start = 1'b1;
      @(negedge clk); start = 1'b0; a = 8'h00; b = 8'h00;
      for (int k = 0; k < 24; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 8) begin start = 1'b1; a = 8'h09; b = 8'h04; end
         if (k == 9) begin
            start = 1'b0; a = 8'h00; b = 8'h00;
            if (done === 1'b1 && diff === 8'h20 && busy === 1'b1) first_ok = 1;
         end
         if (k > 9 && k < 18 && (diff !== 8'h20 || done !== 1'b0)) holdbad++;
         if (k > 9 && done === 1'b1 && lat2 < 0) lat2 = k - 9;
      end
      checks++; if (first_ok !== 1) begin errors++; $display("FAIL b2b_first_done: got %0d expected 1", first_ok); end
      checks++; if (holdbad !== 0) begin errors++; $display("FAIL b2b_hold: got %0d bad cycles expected 0", holdbad); end
      checks++; if (lat2 !== 9) begin errors++; $display("FAIL b2b_latency: got %0d expected 9", lat2); end
      checks++; if (diff !== 8'h05) begin errors++; $display("FAIL b2b_diff: got %h expected 05", diff); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_wrap;
      test_ripple_zero;
      test_start_while_busy;
      test_reset_mid;
      test_back_to_back;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
